// File: rtl/sfu_lut_ctrl_if.sv
// Request/result handshake and the two table read ports of the SFU lookup controller.
// The controller connects through the slave modport; the environment connects through master.
interface sfu_lut_ctrl_if;
  localparam int unsigned OPND_W = 24;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 24;

  logic [OPND_W-1:0] core_operand;
  logic [OPC_W-1:0]  core_special_op;
  logic              valid;
  logic              ready;

  logic [ADDR_W-1:0] rsqrt_rd_addr;
  logic              rsqrt_rd_en;
  logic [DATA_W-1:0] rsqrt_rd_data;

  logic [ADDR_W-1:0] tranc_rd_addr;
  logic              tranc_rd_en;
  logic [DATA_W-1:0] tranc_rd_data;

  logic [RES_W-1:0]  core_result;
  logic              core_valid;

  modport master (
    output core_operand, core_special_op, valid, rsqrt_rd_data, tranc_rd_data,
    input  ready, rsqrt_rd_addr, rsqrt_rd_en, tranc_rd_addr, tranc_rd_en,
           core_result, core_valid
  );

  modport slave (
    input  core_operand, core_special_op, valid, rsqrt_rd_data, tranc_rd_data,
    output ready, rsqrt_rd_addr, rsqrt_rd_en, tranc_rd_addr, tranc_rd_en,
           core_result, core_valid
  );
endinterface

// File: rtl/sfu_lut_ctrl.sv
// Special-function lookup controller: reads two adjacent entries from the rsqrt or tranc
// synchronous ROM and linearly interpolates between them using the operand fraction.
module sfu_lut_ctrl #(
  parameter int unsigned FRAC_W = 8
) (
  input  logic          core_clock_i,
  input  logic          core_reset_i,
  input  logic          flush_i,
  sfu_lut_ctrl_if.slave bus
);
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned RES_W    = 24;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned IDX_LSB  = 14;
  localparam int unsigned FRAC_LSB = IDX_LSB - FRAC_W;
  localparam int unsigned PROD_W   = DATA_W + 1 + FRAC_W;

  localparam logic [IDX_W-1:0] IDX_MAX   = '1;
  localparam logic [OPC_W-1:0] OP_RSQRT  = 3'd0;
  localparam logic [OPC_W-1:0] OP_TRANC  = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                rsqrt_sel_q, rsqrt_sel_d;
  logic                tranc_sel_q, tranc_sel_d;
  logic [DATA_W-1:0]   d0_q, d0_d;
  logic [DATA_W-1:0]   d1_q, d1_d;
  logic [RES_W-1:0]    result_q, result_d;

  logic [IDX_W-1:0]    req_index_c;
  logic [FRAC_W-1:0]   req_frac_c;
  logic [IDX_W-1:0]    next_index_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                accept_c;
  logic                rsqrt_en_c;
  logic                tranc_en_c;
  logic [IDX_W-1:0]    rd_addr_c;
  logic                core_valid_c;

  logic signed [DATA_W:0]   diff_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] shifted_c;
  logic [DATA_W-1:0]        interp_c;
  logic                     unused_opnd;

  assign req_index_c  = bus.core_operand[IDX_LSB +: IDX_W];
  assign req_frac_c   = bus.core_operand[FRAC_LSB +: FRAC_W];
  assign unused_opnd  = ^bus.core_operand;
  assign next_index_c = (index_q == IDX_MAX) ? IDX_MAX : index_q + IDX_W'(1);
  assign sel_data_c   = rsqrt_sel_q ? bus.rsqrt_rd_data : bus.tranc_rd_data;
  assign accept_c     = bus.valid && (state_q == IDLE) && !flush_i && !core_reset_i;

  // Signed slope times unsigned fraction, arithmetic shift back to table scale.
  assign diff_c    = $signed({1'b0, d1_q}) - $signed({1'b0, d0_q});
  assign prod_c    = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac_q}));
  assign shifted_c = prod_c >>> FRAC_W;
  assign interp_c  = d0_q + shifted_c[DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    frac_d       = frac_q;
    rsqrt_sel_d  = rsqrt_sel_q;
    tranc_sel_d  = tranc_sel_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    rsqrt_en_c   = 1'b0;
    tranc_en_c   = 1'b0;
    rd_addr_c    = '0;
    core_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          index_d     = req_index_c;
          frac_d      = req_frac_c;
          rsqrt_sel_d = (bus.core_special_op == OP_RSQRT);
          tranc_sel_d = (bus.core_special_op == OP_TRANC);
          rsqrt_en_c  = (bus.core_special_op == OP_RSQRT);
          tranc_en_c  = (bus.core_special_op == OP_TRANC);
          rd_addr_c   = req_index_c;
          state_d     = RD1;
        end
      end
      RD1: begin
        d0_d       = sel_data_c;
        rsqrt_en_c = rsqrt_sel_q;
        tranc_en_c = tranc_sel_q;
        rd_addr_c  = next_index_c;
        state_d    = CAP;
      end
      CAP: begin
        d1_d    = sel_data_c;
        state_d = OUT;
      end
      OUT: begin
        core_valid_c = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort: no further reads and no result for the dropped operation.
    if (flush_i || core_reset_i) begin
      state_d      = IDLE;
      rsqrt_en_c   = 1'b0;
      tranc_en_c   = 1'b0;
      rd_addr_c    = '0;
      core_valid_c = 1'b0;
    end

    result_d = result_q;
    if (core_valid_c) begin
      result_d = (rsqrt_sel_q || tranc_sel_q) ? RES_W'(interp_c) : '0;
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      state_q     <= IDLE;
      index_q     <= '0;
      frac_q      <= '0;
      rsqrt_sel_q <= 1'b0;
      tranc_sel_q <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      frac_q      <= frac_d;
      rsqrt_sel_q <= rsqrt_sel_d;
      tranc_sel_q <= tranc_sel_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      result_q    <= result_d;
    end
  end

  // Result follows the new value during the valid cycle and holds otherwise.
  assign bus.ready         = (state_q == IDLE);
  assign bus.rsqrt_rd_en   = rsqrt_en_c;
  assign bus.tranc_rd_en   = tranc_en_c;
  assign bus.rsqrt_rd_addr = rsqrt_en_c ? rd_addr_c : '0;
  assign bus.tranc_rd_addr = tranc_en_c ? rd_addr_c : '0;
  assign bus.core_valid    = core_valid_c;
  assign bus.core_result   = result_d;
endmodule
